// File: rtl/serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// serial_mag_comparator
//
// Purpose:
//   Bit-serial magnitude comparator. It scans two WIDTH-bit operands one bit
//   per clock, starting at the MSB. The first bit position where the operands
//   differ decides the word result. K reports A<=B and L reports A>=B, so
//   K=1 with L=1 means the operands are equal.
//
// Optional build macro:
//   EARLY_EXIT_EN - when defined, COMPARE leaves for RESULT in the same cycle
//                   that the first differing bit is found. Equal operands
//                   still take the full WIDTH cycles. The K/L results are the
//                   same in both builds; only the latency changes.
//
// Parameters:
//   WIDTH    operand width in bits (>= 1)
//
// Ports:
//   i_clk    clock; all state changes on the rising edge
//   i_reset  synchronous, active-high reset
//   i_start  request pulse; only sampled while IDLE
//   i_a      operand A, captured on the accepted start edge
//   i_b      operand B, captured on the accepted start edge
//   o_busy   high while in COMPARE
//   o_done   one-cycle pulse in RESULT; o_k/o_l are final
//   o_k      registered word result A<=B
//   o_l      registered word result A>=B
//
// States:
//   ST_IDLE    | waiting for i_start; operands are captured on acceptance
//   ST_COMPARE | one operand bit per cycle, MSB first; o_busy=1
//   ST_RESULT  | one cycle; o_done=1; o_k/o_l hold the final result
// ---------------------------------------------------------------------------
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_k,
    output logic             o_l
);

    // The counter needs at least one bit, even when WIDTH=1.
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_RESULT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_decided;
    logic             r_res_k;
    logic             r_res_l;
    logic             r_k;
    logic             r_l;

    logic             w_a_msb;
    logic             w_b_msb;
    logic             w_diff;
    logic             w_cnt_zero;
    logic             w_exit;
    logic             w_accept;
    logic             w_load_result;
    logic             w_fin_k;
    logic             w_fin_l;

    assign w_a_msb    = r_a[WIDTH-1];
    assign w_b_msb    = r_b[WIDTH-1];
    assign w_diff     = w_a_msb ^ w_b_msb;
    assign w_cnt_zero = (r_cnt == '0);

`ifdef EARLY_EXIT_EN
    // Leave as soon as the first differing bit is seen. In this build,
    // r_decided can never be set while the FSM is still in COMPARE.
    assign w_exit = w_cnt_zero | (~r_decided & w_diff);
`else
    assign w_exit = w_cnt_zero;
`endif

    assign w_accept      = (r_state == ST_IDLE) & i_start;
    assign w_load_result = (r_state == ST_COMPARE) & w_exit;

    // Final result as it will be after the current bit. The current bit is
    // included so that the bit examined in the exit cycle still counts. If no
    // bit ever differed, the operands are equal.
    assign w_fin_k = r_decided ? r_res_k : (w_diff ? w_b_msb : 1'b1);
    assign w_fin_l = r_decided ? r_res_l : (w_diff ? w_a_msb : 1'b1);

    // ----------------------------------------------------------------------
    // FSM state register
    // ----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------------------
    // FSM next-state logic
    // ----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (w_exit) begin
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------------------
    // Datapath: operand shift registers, bit counter, decision tracking
    // ----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_res_k   <= 1'b0;
            r_res_l   <= 1'b0;
        end else if (w_accept) begin
            r_a       <= i_a;
            r_b       <= i_b;
            r_cnt     <= CNT_INIT;
            r_decided <= 1'b0;
            r_res_k   <= 1'b0;
            r_res_l   <= 1'b0;
        end else if (r_state == ST_COMPARE) begin
            // Only the first difference counts. Lower bits can't change the
            // word-level order once a higher bit has decided it.
            if (!r_decided && w_diff) begin
                r_res_k   <= w_b_msb;
                r_res_l   <= w_a_msb;
                r_decided <= 1'b1;
            end
            r_a <= r_a << 1;
            r_b <= r_b << 1;
            if (!w_cnt_zero) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // ----------------------------------------------------------------------
    // Result registers: loaded only on entry to RESULT, so intermediate
    // values never reach the outputs. They hold until the next result or
    // until reset.
    // ----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_k <= 1'b0;
            r_l <= 1'b0;
        end else if (w_load_result) begin
            r_k <= w_fin_k;
            r_l <= w_fin_l;
        end
    end

    assign o_busy = (r_state == ST_COMPARE);
    assign o_done = (r_state == ST_RESULT);
    assign o_k    = r_k;
    assign o_l    = r_l;

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic         o_k;
    logic         o_l;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_k     (o_k),
        .o_l     (o_l)
    );

    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. It works on absolute cycle numbers: a request
    // accepted on an edge becomes a window of COMPARE cycles followed by a
    // single DONE cycle. The result is plain integer comparison.
    // ------------------------------------------------------------------
    int   cyc = 0;
    bit   m_active = 0;
    int   m_done_cyc = 0;
    bit   m_pk, m_pl;
    logic m_k = 1'b0, m_l = 1'b0;

    function automatic int n_compare(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--)
            if (a[i] != b[i]) return W - i;
`endif
        return W;
    endfunction

    always @(posedge i_clk) begin
        int  old_c;
        bit  idle_old;
        old_c = cyc;
        cyc   = cyc + 1;
        if (i_reset) begin
            m_active = 0;
            m_k = 1'b0;
            m_l = 1'b0;
        end else begin
            idle_old = !m_active || (old_c > m_done_cyc);
            if (idle_old) m_active = 0;
            if (idle_old && i_start) begin
                m_active   = 1;
                m_done_cyc = cyc + n_compare(i_a, i_b);
                m_pk       = (i_a <= i_b);
                m_pl       = (i_a >= i_b);
            end
            if (m_active && cyc == m_done_cyc) begin
                m_k = m_pk;
                m_l = m_pl;
            end
        end
    end

    // ------------------------------------------------------------------
    // Every-cycle compare, sampled on the falling edge.
    // ------------------------------------------------------------------
    bit chk_en = 0;
    int done_q[$];

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("busy", 32'(o_busy), 32'(m_active && cyc < m_done_cyc));
            chk("done", 32'(o_done), 32'(m_active && cyc == m_done_cyc));
            chk("k",    32'(o_k),    32'(m_k));
            chk("l",    32'(o_l),    32'(m_l));
            if (o_done === 1'b1) done_q.push_back(cyc);
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Apply a one-cycle start. s is the first COMPARE cycle (t+1).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output int s);
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        run(1);
        i_start = 1'b0;
        s = cyc;
        i_a = ~a;
        i_b = a;
    endtask

    function automatic int last_done();
        if (done_q.size() == 0) return -1;
        return done_q[$];
    endfunction

    initial begin
        int s;
        int nd;
        int per;
        i_reset = 1'b1;
        i_start = 1'b0;
        i_a = '0;
        i_b = '0;
        run(3);
        chk_en = 1;
        @(negedge i_clk);
        chk("reset_k", 32'(o_k), 32'd0);
        chk("reset_l", 32'(o_l), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        run(2);

        // 1: equal operands, full latency in both builds
        nd = done_q.size();
        start_op(8'h5A, 8'h5A, s);
        run(12);
        chk("t1_done_cycle", 32'(last_done()), 32'(s + 8));
        chk("t1_done_count", 32'(done_q.size() - nd), 32'd1);
        chk("t1_k", 32'(o_k), 32'd1);
        chk("t1_l", 32'(o_l), 32'd1);

        // 2: difference at the MSB
        start_op(8'h80, 8'h7F, s);
        run(12);
`ifdef EARLY_EXIT_EN
        chk("t2_done_cycle", 32'(last_done()), 32'(s + 1));
`else
        chk("t2_done_cycle", 32'(last_done()), 32'(s + 8));
`endif
        chk("t2_k", 32'(o_k), 32'd0);
        chk("t2_l", 32'(o_l), 32'd1);

        // 3: difference only at bit 0
        start_op(8'h12, 8'h13, s);
        run(12);
        chk("t3_done_cycle", 32'(last_done()), 32'(s + 8));
        chk("t3_k", 32'(o_k), 32'd1);
        chk("t3_l", 32'(o_l), 32'd0);

        // 4: a second start while busy is ignored
        nd = done_q.size();
        start_op(8'h01, 8'h02, s);
        run(2);
        i_a = 8'hFF;
        i_b = 8'h00;
        i_start = 1'b1;
        run(1);
        i_start = 1'b0;
        run(14);
        chk("t4_done_count", 32'(done_q.size() - nd), 32'd1);
        chk("t4_k", 32'(o_k), 32'd1);
        chk("t4_l", 32'(o_l), 32'd0);

        // 5: reset in the middle of an operation
        nd = done_q.size();
        start_op(8'h00, 8'hFF, s);
        run(2);
        i_reset = 1'b1;
        run(1);
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("t5_busy", 32'(o_busy), 32'd0);
        chk("t5_done", 32'(o_done), 32'd0);
        chk("t5_k", 32'(o_k), 32'd0);
        chk("t5_l", 32'(o_l), 32'd0);
        run(12);
`ifdef EARLY_EXIT_EN
        // The MSB differs, so this build finishes before the reset arrives.
        chk("t5_done_count", 32'(done_q.size() - nd), 32'd1);
`else
        chk("t5_done_count", 32'(done_q.size() - nd), 32'd0);
`endif
        start_op(8'h03, 8'h03, s);
        run(12);
        chk("t5b_done_cycle", 32'(last_done()), 32'(s + 8));
        chk("t5b_k", 32'(o_k), 32'd1);
        chk("t5b_l", 32'(o_l), 32'd1);

        // 6: start held high, so operations run back to back
        done_q.delete();
        i_a = 8'h10;
        i_b = 8'h20;
        i_start = 1'b1;
        run(45);
        i_start = 1'b0;
        run(14);
`ifdef EARLY_EXIT_EN
        per = 5;
`else
        per = 10;
`endif
        chk("t6_pulses", 32'(done_q.size() >= 4), 32'd1);
        for (int i = 1; i < done_q.size(); i++)
            chk("t6_period", 32'(done_q[i] - done_q[i-1]), 32'(per));
        chk("t6_k", 32'(o_k), 32'd1);
        chk("t6_l", 32'(o_l), 32'd0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
